// File: rtl/spi_master_sequencer.sv
// Mode-0 SPI master sequencer: drives an external shift register (parallel
// load, one left shift per bit), generates sclk / cs_n and samples MISO on
// the rising sclk side. The only data it holds is the sampled MISO bit.
module spi_master_sequencer #(
    parameter int width   = 8,   // bits per transfer, equal to the shift register width
    parameter int CLK_DIV = 2    // clk cycles per sclk high phase and per low phase (>= 1)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic       miso,
    output logic [1:0] sr_mode,
    output logic       sr_serial_in,
    output logic       sclk,
    output logic       cs_n,
    output logic       busy,
    output logic       done
);

    // Counter widths never collapse to zero bits, even for CLK_DIV=1 or width=1.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (width > 1) ? $clog2(width) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(width - 1);

    // Shift register mode encoding (RIGHT=01 is never requested by this block).
    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_PLOAD = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        LOW    = 3'd2,
        HIGH   = 3'd3,
        SHIFT  = 3'd4,
        FINISH = 3'd5
    } seqState_t;

    seqState_t        stateReg;
    seqState_t        stateNext;
    logic [DIV_W-1:0] divCntReg;
    logic [BIT_W-1:0] bitCntReg;
    logic             rxBitReg;

    logic divDone;
    logic bitLast;

    assign divDone = (divCntReg == DIV_LAST);
    assign bitLast = (bitCntReg == BIT_LAST);

    // State register; reset abandons any transfer without a done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Phase/bit counters and the MISO sample taken on the edge leaving LOW.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            divCntReg <= '0;
            bitCntReg <= '0;
            rxBitReg  <= 1'b0;
        end else begin
            case (stateReg)
                LOAD: begin
                    divCntReg <= '0;
                    bitCntReg <= '0;
                end
                LOW: begin
                    if (divDone) begin
                        divCntReg <= '0;
                        rxBitReg  <= miso;   // sclk rises as we leave LOW
                    end else begin
                        divCntReg <= divCntReg + 1'b1;
                    end
                end
                HIGH: begin
                    if (divDone) begin
                        divCntReg <= '0;
                    end else begin
                        divCntReg <= divCntReg + 1'b1;
                    end
                end
                SHIFT: begin
                    // Saturate on the last bit so the counter never wraps.
                    if (!bitLast) begin
                        bitCntReg <= bitCntReg + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state logic; abort cancels any active phase, start only counts in IDLE.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:   if (start) stateNext = LOAD;
            LOAD:   stateNext = abort ? IDLE : LOW;
            LOW:    if (abort) stateNext = IDLE;
                    else if (divDone) stateNext = HIGH;
            HIGH:   if (abort) stateNext = IDLE;
                    else if (divDone) stateNext = SHIFT;
            SHIFT:  if (abort) stateNext = IDLE;
                    else stateNext = bitLast ? FINISH : LOW;
            FINISH: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Moore output decode from the registered state only.
    always_comb begin
        sr_mode = MODE_HOLD;
        sclk    = 1'b0;
        cs_n    = 1'b1;
        busy    = 1'b0;
        done    = 1'b0;
        case (stateReg)
            LOAD: begin
                sr_mode = MODE_PLOAD;
                cs_n    = 1'b0;
                busy    = 1'b1;
            end
            LOW: begin
                cs_n = 1'b0;
                busy = 1'b1;
            end
            HIGH: begin
                sclk = 1'b1;
                cs_n = 1'b0;
                busy = 1'b1;
            end
            SHIFT: begin
                sr_mode = MODE_LEFT;
                cs_n    = 1'b0;
                busy    = 1'b1;
            end
            FINISH: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // The shift register only consumes this bit during SHIFT; it always
    // mirrors the registered MISO sample.
    assign sr_serial_in = rxBitReg;

endmodule

// File: tb/tb_spi_master_sequencer.sv
// Bench for spi_master_sequencer: two instances (CLK_DIV=2 and CLK_DIV=1),
// each with a behavioural 8-bit shift register and a mode-0 slave.
module tb_spi_master_sequencer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;

    logic [1:0]      miso;
    logic [1:0][1:0] srMode;
    logic [1:0]      serIn;
    logic [1:0]      sclk;
    logic [1:0]      csN;
    logic [1:0]      busy;
    logic [1:0]      done;

    logic [7:0] sr    [2];
    logic [7:0] slave [2];
    logic       slvPrevSclk [2];

    bit         loopback = 1'b1;
    logic [7:0] txData   = 8'h00;
    logic [7:0] slavePat = 8'h00;

    int passCnt  = 0;
    int checkCnt = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        spi_master_sequencer #(.width(8), .CLK_DIV((gi == 0) ? 2 : 1)) u_dut (
            .clk          (clk),
            .reset_n      (reset_n),
            .start        (start),
            .abort        (abort),
            .miso         (miso[gi]),
            .sr_mode      (srMode[gi]),
            .sr_serial_in (serIn[gi]),
            .sclk         (sclk[gi]),
            .cs_n         (csN[gi]),
            .busy         (busy[gi]),
            .done         (done[gi])
        );

        // External shift register the sequencer drives.
        always @(posedge clk) begin
            case (srMode[gi])
                2'b11: sr[gi] <= txData;
                2'b10: sr[gi] <= {sr[gi][6:0], serIn[gi]};
                2'b01: sr[gi] <= {serIn[gi], sr[gi][7:1]};
                default: sr[gi] <= sr[gi];
            endcase
        end

        // Mode-0 slave: pattern reloads while deselected, next bit after each sclk fall.
        always @(negedge clk) begin
            if (csN[gi]) begin
                slave[gi] <= slavePat;
            end else if (slvPrevSclk[gi] && !sclk[gi]) begin
                slave[gi] <= {slave[gi][6:0], 1'b0};
            end
            slvPrevSclk[gi] <= sclk[gi];
        end

        assign miso[gi] = loopback ? sr[gi][7] : slave[gi][7];
    end

    task automatic check(input string name, input int act, input int exp);
        checkCnt++;
        if (act == exp) passCnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: per-bit period and done latency from the timing rules.
    function automatic int divOf(input int s);
        return (s == 0) ? 2 : 1;
    endfunction

    function automatic int latencyOf(input int s);
        return 1 + 8 * (2 * divOf(s) + 1);
    endfunction

    function automatic int outVec(input int s);
        return int'({srMode[s], sclk[s], csN[s], busy[s], done[s]});
    endfunction

    task automatic doReset();
        @(negedge clk);
        reset_n = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // One full transfer on instance s, checked against the reference model.
    task automatic doTransfer(input int s, input bit lb, input logic [7:0] tx,
                              input logic [7:0] pat, input bit poke);
        logic [7:0] expRx;
        int lat, rises, lefts, loads, doneAt, postLoads;
        bit prevS, got;
        loopback = lb;
        txData   = tx;
        slavePat = pat;
        expRx = lb ? tx : pat;
        lat   = latencyOf(s);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("pload_after_start", int'(srMode[s]), 3);
        rises = 0; lefts = 0; loads = 0; doneAt = -1; prevS = 1'b0; got = 1'b0;
        for (int cyc = 1; cyc <= 200 && !got; cyc++) begin
            @(negedge clk);
            start = poke && (cyc == 10);
            if (srMode[s] == 2'b11) loads++;
            if (srMode[s] == 2'b10) begin
                if (lefts < 8) check("serial_in_at_shift", int'(serIn[s]), int'(expRx[7 - lefts]));
                lefts++;
            end
            if (sclk[s] && !prevS) begin
                if (rises < 8) check("mosi_at_sclk_rise", int'(sr[s][7]), int'(tx[7 - rises]));
                rises++;
            end
            prevS = sclk[s];
            if (done[s]) begin
                doneAt = cyc;
                got = 1'b1;
            end
        end
        start = 1'b0;
        check("done_latency", doneAt, lat);
        check("sclk_rises", rises, 8);
        check("left_cycles", lefts, 8);
        check("extra_ploads", loads, 0);
        check("rx_data", int'(sr[s]), int'(expRx));
        $display("xfer inst=%0d lb=%0d tx=%02h pat=%02h poke=%0d -> rx=%02h done@%0d",
                 s, lb, tx, pat, poke, sr[s], doneAt);
        @(negedge clk);
        check("done_one_cycle", int'({done[s], csN[s]}), 1);
        postLoads = 0;
        repeat (3) begin
            @(negedge clk);
            if (srMode[s] == 2'b11) postLoads++;
        end
        check("start_not_queued", postLoads, 0);
    endtask

    typedef struct {
        logic       st;
        logic       ab;
        logic [5:0] exp;   // {sr_mode, sclk, cs_n, busy, done}
    } vecT;

    localparam logic [5:0] O_IDLE  = 6'b00_0_1_0_0;
    localparam logic [5:0] O_LOAD  = 6'b11_0_0_1_0;
    localparam logic [5:0] O_LOW   = 6'b00_0_0_1_0;
    localparam logic [5:0] O_HIGH  = 6'b00_1_0_1_0;
    localparam logic [5:0] O_SHIFT = 6'b10_0_0_1_0;

    initial begin
        vecT vecs [13];
        int loadAt [$];
        int dones, gap, waitCnt, lefts;
        bit found;

        // Cycle-by-cycle vectors for the CLK_DIV=2 instance.
        vecs[0]  = '{1'b1, 1'b0, O_IDLE};
        vecs[1]  = '{1'b0, 1'b0, O_LOAD};
        vecs[2]  = '{1'b0, 1'b0, O_LOW};
        vecs[3]  = '{1'b0, 1'b0, O_LOW};
        vecs[4]  = '{1'b0, 1'b0, O_HIGH};
        vecs[5]  = '{1'b0, 1'b0, O_HIGH};
        vecs[6]  = '{1'b0, 1'b0, O_SHIFT};
        vecs[7]  = '{1'b0, 1'b1, O_LOW};    // abort mid bit
        vecs[8]  = '{1'b1, 1'b1, O_IDLE};   // start+abort in IDLE: start wins
        vecs[9]  = '{1'b1, 1'b0, O_LOAD};   // start while busy: ignored
        vecs[10] = '{1'b0, 1'b1, O_LOW};
        vecs[11] = '{1'b0, 1'b0, O_IDLE};
        vecs[12] = '{1'b0, 1'b0, O_IDLE};

        // Reset values, both instances.
        #1;
        check("reset_outputs_i0", outVec(0), int'(O_IDLE));
        check("reset_outputs_i1", outVec(1), int'(O_IDLE));
        check("reset_serial_in", int'(serIn), 0);
        doReset();

        for (int i = 0; i < 13; i++) begin
            check($sformatf("vector_%0d", i), outVec(0), int'(vecs[i].exp));
            $display("vec %0d start=%0d abort=%0d out=%06b", i, vecs[i].st, vecs[i].ab, outVec(0));
            start = vecs[i].st;
            abort = vecs[i].ab;
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;

        // Directed transfers from the test plan.
        doReset();
        doTransfer(0, 1'b1, 8'hA5, 8'h00, 1'b0);
        doReset();
        doTransfer(1, 1'b0, 8'hFF, 8'h3C, 1'b0);
        doReset();
        doTransfer(0, 1'b0, 8'h81, 8'h6E, 1'b1);

        // Randomized transfers.
        for (int t = 0; t < 10; t++) begin
            doReset();
            doTransfer(int'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                       8'($urandom), 8'($urandom), 1'($urandom_range(1, 0)));
        end

        // start held high: back-to-back transfers with one IDLE cycle between.
        doReset();
        loopback = 1'b1;
        txData = 8'hC3;
        start = 1'b1;
        dones = 0;
        gap = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            if (srMode[0] == 2'b11) loadAt.push_back(cyc);
            if (done[0]) dones++;
            if (loadAt.size() == 1 && csN[0]) gap++;
        end
        start = 1'b0;
        check("b2b_load_count", loadAt.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < loadAt.size())
                check("b2b_load_offset", loadAt[k] - loadAt[0], k * (latencyOf(0) + 2));
        end
        check("b2b_done_count", dones, 2);
        check("b2b_cs_gap", gap, 2);
        $display("b2b loads=%0d dones=%0d gap=%0d", loadAt.size(), dones, gap);

        // Asynchronous reset asserted mid-HIGH.
        doReset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (waitCnt = 0; waitCnt < 20 && !found; waitCnt++) begin
            @(negedge clk);
            if (sclk[0]) found = 1'b1;
        end
        check("reach_high_phase", int'(found), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", outVec(0), int'(O_IDLE));
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        repeat (60) begin
            @(negedge clk);
            if (done[0]) dones++;
        end
        check("no_done_after_reset", dones, 0);
        $display("reset mid-HIGH: outputs idle, dones=%0d", dones);

        // Abort during the LOW phase of bit 3, then a normal transfer.
        doReset();
        loopback = 1'b1;
        txData = 8'h96;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lefts = 0;
        found = 1'b0;
        for (waitCnt = 0; waitCnt < 100 && !found; waitCnt++) begin
            @(negedge clk);
            if (srMode[0] == 2'b10) lefts++;
            else if (lefts == 3 && outVec(0) == int'(O_LOW)) found = 1'b1;
        end
        check("reach_bit3_low", int'(found), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_outputs", outVec(0), int'(O_IDLE));
        dones = 0;
        repeat (50) begin
            @(negedge clk);
            if (done[0]) dones++;
        end
        check("no_done_after_abort", dones, 0);
        $display("abort bit3: dones=%0d", dones);
        doTransfer(0, 1'b1, 8'h5A, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/spi_master_sequencer.md
Name: spi_master_sequencer

Overview:
- Sequences one 8-bit shift register as a mode-0 SPI master (CPOL=0, CPHA=0): parallel-loads TX data, generates sclk and cs_n, samples MISO, and commands one left shift per bit.
- Sits between the host request logic and the shift register. The shift register's parallelIn carries TX data, its serialOut (MSB) drives MOSI, and its parallelOut holds RX data after done.
- The block owns no data register except the sampled MISO bit.

Parameters:
width, 8, bits per transfer; must match the shift register width
CLK_DIV, 2, clk cycles per sclk high phase and per sclk low phase; legal range is 1 or greater

Ports:
clk  input  1  system clock; all state updates on posedge
reset_n  input  1  asynchronous, active-low reset
start  input  1  request a transfer; sampled only in IDLE
abort  input  1  synchronous cancel of an in-progress transfer
miso  input  1  serial data from slave
sr_mode  output  2  shift register mode: HOLD=00, RIGHT=01, LEFT=10, PLOAD=11
sr_serial_in  output  1  bit shifted into the shift register LSB; equals the registered MISO sample
sclk  output  1  SPI clock, idle low
cs_n  output  1  active-low chip select
busy  output  1  high from LOAD through the last SHIFT
done  output  1  one-cycle pulse when a transfer completes

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset: on reset_n low, immediately force state=IDLE, sclk=0, cs_n=1, sr_mode=HOLD, busy=0, done=0, sr_serial_in=0, and clear all counters. Same values apply while reset_n is held low. A reset mid-transfer abandons the transfer with no done.
- Output style: Moore. All outputs decode from registered state plus the registered rx_bit; nothing is combinational from inputs.
- IDLE: cs_n=1, sclk=0, sr_mode=HOLD. start=1 moves to LOAD.
- LOAD (1 cycle): sr_mode=PLOAD, cs_n=0, busy=1. Clear bit_cnt and div_cnt, then go to LOW.
- LOW: sclk=0, sr_mode=HOLD, lasts CLK_DIV cycles. On the edge leaving LOW, rx_bit <= miso (rising-sclk sample), then go to HIGH.
- HIGH: sclk=1, sr_mode=HOLD, lasts CLK_DIV cycles, then go to SHIFT.
- SHIFT (1 cycle): sclk=0, sr_mode=LEFT, sr_serial_in=rx_bit, bit_cnt increments. If bit_cnt was width-1, go to FINISH; otherwise go to LOW.
- FINISH (1 cycle): cs_n=1, busy=0, done=1, sr_mode=HOLD, then go to IDLE unconditionally.
- Per-bit period: 2*CLK_DIV+1 clk cycles. sclk low time is CLK_DIV+1 cycles, high time is CLK_DIV cycles.
- MOSI timing: MOSI (the shift register MSB) changes only on the SHIFT edge, i.e. on the sclk falling side.
- Latency: with LOAD at cycle t0, done is high at cycle t0+1+width*(2*CLK_DIV+1). For defaults this is t0+41. sclk shows exactly width rising edges per transfer.
- start while not in IDLE: ignored, not queued. start held high continuously gives back-to-back transfers, with one IDLE cycle between FINISH and the next LOAD.
- abort: in LOAD, LOW, HIGH or SHIFT, the next state is IDLE. sclk=0 and cs_n=1 the next cycle, no done, and shift register contents are undefined for the host. abort in IDLE or FINISH has no effect; FINISH still produces done.
- Simultaneous start and abort in IDLE: start wins, abort is ignored.
- Counters: div_cnt is sized to hold CLK_DIV-1 and bit_cnt to hold width-1. Neither wraps inside a transfer; both clear in LOAD.

Test Plan:
- Reset: hold reset_n=0 mid-HIGH (sclk=1) -> same cycle sclk=0, cs_n=1, sr_mode=00, busy=0; no done ever follows.
- Loopback (miso tied to MOSI), TX=8'hA5, defaults: start 1 cycle -> one PLOAD cycle, 8 LEFT cycles, 8 sclk rising edges, done at t0+41, parallelOut=8'hA5.
- Fixed slave pattern 8'h3C on miso (MSB first, changing on sclk falling), TX=8'hFF, CLK_DIV=1 -> done at t0+25, parallelOut=8'h3C, MOSI samples 1 at every sclk rise.
- start held high for 100 cycles -> LOAD at cycles t0, t0+43, t0+86; exactly 2 done pulses; cs_n high for exactly 2 cycles between transfers.
- abort asserted during bit 3 LOW -> next cycle IDLE, cs_n=1, sclk=0, no done; a subsequent start completes normally with correct data.
- start pulsed while busy, and start+abort together in IDLE -> busy start ignored with done count unchanged; IDLE case enters LOAD.
